// File: rtl/uart_rx_fifo_trig.sv
// uart_rx_fifo_trig
// Parametrised UART receive FIFO. Each entry holds a received character and
// its line-status flags ({break, parity, frame, data}). Provides occupancy
// status, an error-present flag, an overrun pulse, a trigger-level interrupt
// and a character-timeout interrupt.
// Optional feature macro: UART_RX_FIFO_TIMEOUT_EN (defined -> timeout counter
// and timeoutIrq present; undefined -> timeoutIrq tied low, baudTick and
// timeoutTicks unused).
module uart_rx_fifo_trig #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  fifoWe,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  frameErrorIn,
  input  logic                  parityErrorIn,
  input  logic                  breakIn,
  input  logic                  fifoRe,
  input  logic [DEPTH_LOG2:0]   triggerLevel,
  input  logic                  baudTick,
  input  logic [15:0]           timeoutTicks,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  frameErrorOut,
  output logic                  parityErrorOut,
  output logic                  breakOut,
  output logic                  fifoEmpty,
  output logic                  fifoFull,
  output logic [DEPTH_LOG2:0]   nrOfEntries,
  output logic                  fifoError,
  output logic                  overrun,
  output logic                  dataAvailIrq,
  output logic                  timeoutIrq
);

  localparam int                  DEPTH    = 2**DEPTH_LOG2;
  localparam int                  WORD_W   = DATA_WIDTH + 3;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [WORD_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   r_err_cnt;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_error;
  logic                  r_overrun;

  logic [WORD_W-1:0]     w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_push_err;
  logic                  w_pop_err;
  logic [DEPTH_LOG2:0]   w_cnt_next;
  logic [DEPTH_LOG2:0]   w_err_next;

  // Head word is read straight out of registered storage
  assign w_head         = r_mem[r_rd_ptr];
  assign dataOut        = w_head[DATA_WIDTH-1:0];
  assign frameErrorOut  = w_head[DATA_WIDTH];
  assign parityErrorOut = w_head[DATA_WIDTH+1];
  assign breakOut       = w_head[DATA_WIDTH+2];

  // A pop is only honoured when data is present; a push on a full FIFO is
  // accepted only if the head is leaving in the same cycle. Flush wins.
  assign w_pop      = fifoRe && !r_empty && !flush;
  assign w_push     = fifoWe && (!r_full || fifoRe) && !flush;
  assign w_push_err = w_push && (frameErrorIn || parityErrorIn || breakIn);
  assign w_pop_err  = w_pop && (|w_head[WORD_W-1:DATA_WIDTH]);

  assign fifoEmpty    = r_empty;
  assign fifoFull     = r_full;
  assign nrOfEntries  = r_count;
  assign fifoError    = r_error;
  assign overrun      = r_overrun;
  assign dataAvailIrq = (triggerLevel != '0) && (r_count >= triggerLevel);

  // Next occupancy and next flagged-entry count
  always_comb begin
    w_cnt_next = r_count;
    w_err_next = r_err_cnt;
    if (flush) begin
      w_cnt_next = '0;
      w_err_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_cnt_next = r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   w_cnt_next = r_count - (DEPTH_LOG2+1)'(1);
        default: w_cnt_next = r_count;
      endcase
      case ({w_push_err, w_pop_err})
        2'b10:   w_err_next = r_err_cnt + (DEPTH_LOG2+1)'(1);
        2'b01:   w_err_next = r_err_cnt - (DEPTH_LOG2+1)'(1);
        default: w_err_next = r_err_cnt;
      endcase
    end
  end

  // Character storage; cleared on reset so the head reads zero afterwards
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {breakIn, parityErrorIn, frameErrorIn, dataIn};
    end
  end

  // Pointers, occupancy, error counter and registered status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_error   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_count   <= w_cnt_next;
      r_err_cnt <= w_err_next;
      r_empty   <= (w_cnt_next == '0);
      r_full    <= (w_cnt_next == CNT_FULL);
      r_error   <= (w_err_next != '0);
      r_overrun <= fifoWe && r_full && !fifoRe && !flush;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_tmo_irq;
  logic [15:0] w_tmo_next;
  logic        w_tmo_irq_next;

  // Idle time counter in baud ticks and the interrupt it raises; the
  // interrupt compares against the updated count so it follows the tick
  // by one cycle
  always_comb begin
    w_tmo_next     = r_tmo_cnt;
    w_tmo_irq_next = r_tmo_irq;
    if (flush || w_push || w_pop || r_empty) begin
      w_tmo_next = 16'd0;
    end else if (baudTick && (r_tmo_cnt != 16'hFFFF)) begin
      w_tmo_next = r_tmo_cnt + 16'd1;
    end else begin
      w_tmo_next = r_tmo_cnt;
    end
    if (flush || w_push || w_pop || (timeoutTicks == 16'd0)) begin
      w_tmo_irq_next = 1'b0;
    end else if (w_tmo_next == timeoutTicks) begin
      w_tmo_irq_next = 1'b1;
    end else begin
      w_tmo_irq_next = r_tmo_irq;
    end
  end

  // Timeout counter and interrupt registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= 16'd0;
      r_tmo_irq <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_next;
      r_tmo_irq <= w_tmo_irq_next;
    end
  end

  assign timeoutIrq = r_tmo_irq;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = &{1'b0, baudTick, timeoutTicks};
  assign timeoutIrq   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_trig.sv
// Testbench for uart_rx_fifo_trig: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_uart_rx_fifo_trig;

  localparam int DW    = 8;
  localparam int DL    = 4;
  localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          fifoWe;
  logic [DW-1:0] dataIn;
  logic          frameErrorIn, parityErrorIn, breakIn;
  logic          fifoRe;
  logic [DL:0]   triggerLevel;
  logic          baudTick;
  logic [15:0]   timeoutTicks;
  logic [DW-1:0] dataOut;
  logic          frameErrorOut, parityErrorOut, breakOut;
  logic          fifoEmpty, fifoFull;
  logic [DL:0]   nrOfEntries;
  logic          fifoError, overrun, dataAvailIrq, timeoutIrq;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [10:0] m_q[$];
  bit          m_ovr;
  int          m_tmo;
  bit          m_tirq;

  always #5 clock = ~clock;

  uart_rx_fifo_trig #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clock(clock), .reset(reset), .flush(flush), .fifoWe(fifoWe),
    .dataIn(dataIn), .frameErrorIn(frameErrorIn), .parityErrorIn(parityErrorIn),
    .breakIn(breakIn), .fifoRe(fifoRe), .triggerLevel(triggerLevel),
    .baudTick(baudTick), .timeoutTicks(timeoutTicks), .dataOut(dataOut),
    .frameErrorOut(frameErrorOut), .parityErrorOut(parityErrorOut),
    .breakOut(breakOut), .fifoEmpty(fifoEmpty), .fifoFull(fifoFull),
    .nrOfEntries(nrOfEntries), .fifoError(fifoError), .overrun(overrun),
    .dataAvailIrq(dataAvailIrq), .timeoutIrq(timeoutIrq)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_q.delete();
    m_ovr  = 1'b0;
    m_tmo  = 0;
    m_tirq = 1'b0;
  endfunction

  // Apply the inputs seen at a rising edge to the model
  function automatic void model_update();
    bit was_empty, was_full, do_pop, do_push;
    was_empty = (m_q.size() == 0);
    was_full  = (m_q.size() == DEPTH);
    if (flush) begin
      model_clear();
    end else begin
      do_pop  = fifoRe && !was_empty;
      do_push = fifoWe && (!was_full || fifoRe);
      m_ovr   = fifoWe && was_full && !fifoRe;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back({breakIn, parityErrorIn, frameErrorIn, dataIn});
      // baud ticks elapsed since the last FIFO activity while data waits
      if (do_push || do_pop || was_empty) m_tmo = 0;
      else if (baudTick && m_tmo < 65535) m_tmo++;
      if (do_push || do_pop || timeoutTicks == 16'd0) m_tirq = 1'b0;
      else if (m_tmo == int'(timeoutTicks)) m_tirq = 1'b1;
    end
  endfunction

  task automatic check_all();
    bit any_err;
    any_err = 1'b0;
    foreach (m_q[i]) if (m_q[i][10:8] != 3'b000) any_err = 1'b1;
    check_value("nrOfEntries", 32'(nrOfEntries), 32'(m_q.size()));
    check_value("fifoEmpty", 32'(fifoEmpty), 32'(m_q.size() == 0));
    check_value("fifoFull", 32'(fifoFull), 32'(m_q.size() == DEPTH));
    check_value("fifoError", 32'(fifoError), 32'(any_err));
    check_value("overrun", 32'(overrun), 32'(m_ovr));
    check_value("dataAvailIrq", 32'(dataAvailIrq),
                32'((triggerLevel != 0) && (m_q.size() >= int'(triggerLevel))));
    check_value("timeoutIrq", 32'(timeoutIrq), 32'(TMO_EN && m_tirq));
    if (m_q.size() != 0)
      check_value("head", 32'({breakOut, parityErrorOut, frameErrorOut, dataOut}), 32'(m_q[0]));
  endtask

  task automatic reset_checks(input string tag);
    check_value({tag, "_empty"}, 32'(fifoEmpty), 32'd1);
    check_value({tag, "_full"}, 32'(fifoFull), 32'd0);
    check_value({tag, "_count"}, 32'(nrOfEntries), 32'd0);
    check_value({tag, "_error"}, 32'(fifoError), 32'd0);
    check_value({tag, "_overrun"}, 32'(overrun), 32'd0);
    check_value({tag, "_avail"}, 32'(dataAvailIrq), 32'd0);
    check_value({tag, "_tmo"}, 32'(timeoutIrq), 32'd0);
    check_value({tag, "_head"}, 32'({breakOut, parityErrorOut, frameErrorOut, dataOut}), 32'd0);
  endtask

  // One clock: inputs are already set; model at the edge, check at the falling edge
  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    check_all();
  endtask

  task automatic do_cycle(input bit we, input bit re, input logic [7:0] d,
                          input logic [2:0] fl, input bit tick);
    fifoWe = we;
    fifoRe = re;
    dataIn = d;
    {breakIn, parityErrorIn, frameErrorIn} = fl;
    baudTick = tick;
    step();
  endtask

  initial begin
    int pw, pr;
    logic [7:0] exp_d;
    reset = 1'b0; flush = 1'b0; fifoWe = 1'b0; fifoRe = 1'b0; dataIn = '0;
    frameErrorIn = 1'b0; parityErrorIn = 1'b0; breakIn = 1'b0;
    triggerLevel = '0; baudTick = 1'b0; timeoutTicks = 16'd0;
    model_clear();
    repeat (3) @(negedge clock);
    reset_checks("reset");
    reset = 1'b1;

    // Fill to full, then overrun
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 8'(8'h41 + i), 3'b000, 1'b0);
    check_value("full_after16", 32'(fifoFull), 32'd1);
    check_value("count_after16", 32'(nrOfEntries), 32'd16);
    do_cycle(1'b1, 1'b0, 8'h51, 3'b000, 1'b0);
    check_value("overrun_pulse", 32'(overrun), 32'd1);
    check_value("count_after_drop", 32'(nrOfEntries), 32'd16);
    do_cycle(1'b0, 1'b0, 8'h00, 3'b000, 1'b0);
    check_value("overrun_one_cycle", 32'(overrun), 32'd0);
    // Push and pop on a full FIFO
    do_cycle(1'b1, 1'b1, 8'h7A, 3'b000, 1'b0);
    check_value("full_pushpop_count", 32'(nrOfEntries), 32'd16);
    check_value("full_pushpop_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) begin
      exp_d = (i < 15) ? 8'(8'h42 + i) : 8'h7A;
      check_value("pop_order", 32'(dataOut), 32'(exp_d));
      do_cycle(1'b0, 1'b1, 8'h00, 3'b000, 1'b0);
    end
    check_value("empty_after_pops", 32'(fifoEmpty), 32'd1);

    // Trigger level
    triggerLevel = 5'd4;
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 8'(8'h10 + i), 3'b000, 1'b0);
    check_value("trig_below", 32'(dataAvailIrq), 32'd0);
    do_cycle(1'b1, 1'b0, 8'h13, 3'b000, 1'b0);
    check_value("trig_reached", 32'(dataAvailIrq), 32'd1);
    do_cycle(1'b0, 1'b1, 8'h00, 3'b000, 1'b0);
    check_value("trig_after_pop", 32'(dataAvailIrq), 32'd0);
    repeat (3) do_cycle(1'b0, 1'b1, 8'h00, 3'b000, 1'b0);
    triggerLevel = '0;

    // Parity-flagged entry among clean ones
    do_cycle(1'b1, 1'b0, 8'h20, 3'b000, 1'b0);
    do_cycle(1'b1, 1'b0, 8'h21, 3'b010, 1'b0);
    do_cycle(1'b1, 1'b0, 8'h22, 3'b000, 1'b0);
    check_value("ferr_set", 32'(fifoError), 32'd1);
    check_value("par_not_head", 32'(parityErrorOut), 32'd0);
    do_cycle(1'b0, 1'b1, 8'h00, 3'b000, 1'b0);
    check_value("par_head", 32'(parityErrorOut), 32'd1);
    do_cycle(1'b0, 1'b1, 8'h00, 3'b000, 1'b0);
    check_value("ferr_clear", 32'(fifoError), 32'd0);
    check_value("par_gone", 32'(parityErrorOut), 32'd0);
    do_cycle(1'b0, 1'b1, 8'h00, 3'b000, 1'b0);

    // Character timeout
    timeoutTicks = 16'd64;
    do_cycle(1'b1, 1'b0, 8'h55, 3'b000, 1'b0);
    for (int i = 0; i < 64; i++) begin
      do_cycle(1'b0, 1'b0, 8'h00, 3'b000, 1'b1);
      do_cycle(1'b0, 1'b0, 8'h00, 3'b000, 1'b0);
    end
    check_value("tmo_set", 32'(timeoutIrq), 32'(TMO_EN));
    do_cycle(1'b0, 1'b1, 8'h00, 3'b000, 1'b0);
    check_value("tmo_cleared", 32'(timeoutIrq), 32'd0);

    // Randomized traffic in blocks with varying push/pop rates
    for (int b = 0; b < 16; b++) begin
      pw = int'($urandom_range(0, 3)) * 30 + 5;
      pr = int'($urandom_range(0, 3)) * 30 + 5;
      triggerLevel = 5'($urandom_range(0, 16));
      timeoutTicks = 16'($urandom_range(0, 12));
      for (int c = 0; c < 200; c++) begin
        flush = ($urandom_range(0, 199) == 0);
        do_cycle($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom()),
                 {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0},
                 $urandom_range(0, 1) == 1);
      end
    end
    flush = 1'b1;
    do_cycle(1'b1, 1'b0, 8'h99, 3'b000, 1'b0);
    check_value("flush_drops_push", 32'(nrOfEntries), 32'd0);
    flush = 1'b0;

    // Reset in the middle of operation
    triggerLevel = 5'd2;
    timeoutTicks = 16'd8;
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 8'(8'h60 + i), 3'b001, 1'b0);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b0, 8'h00, 3'b000, 1'b1);
    check_value("pre_reset_tmo", 32'(timeoutIrq), 32'(TMO_EN));
    check_value("pre_reset_count", 32'(nrOfEntries), 32'd5);
    fifoWe = 1'b0; fifoRe = 1'b0; baudTick = 1'b0;
    {breakIn, parityErrorIn, frameErrorIn} = 3'b000;
    #2 reset = 1'b0;
    #1 reset_checks("midreset");
    @(negedge clock);
    reset_checks("midreset_hold");
    reset = 1'b1;
    model_clear();
    do_cycle(1'b1, 1'b0, 8'h33, 3'b000, 1'b0);
    check_value("post_reset_data", 32'(dataOut), 32'h33);
    check_value("post_reset_count", 32'(nrOfEntries), 32'd1);
    do_cycle(1'b0, 1'b0, 8'h00, 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo_trig.md
# uart_rx_fifo_trig

Parametrised receive FIFO for the bus-attached UART, replacing the fixed 16-entry receive FIFO. It buffers received characters together with their per-character line-status flags. It exposes a programmable trigger-level interrupt, an overrun pulse, and a character-timeout interrupt. It sits between the UART receiver (push side) and the bus register file (pop side, receiver-buffer read).

## Interface
- DATA_WIDTH, 8, character width in bits (5..9)
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (2..8)
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- flush  input  1  synchronous clear of contents, counters and interrupts
- fifoWe  input  1  push request from receiver
- dataIn  input  DATA_WIDTH  received character
- frameErrorIn, parityErrorIn, breakIn  input  1 each  flags stored with the character
- fifoRe  input  1  pop request (head entry consumed)
- triggerLevel  input  DEPTH_LOG2+1  data-available threshold; 0 disables
- baudTick  input  1  one-cycle pulse at 16x baud rate
- timeoutTicks  input  16  character-timeout limit in baudTick units; 0 disables
- dataOut  output  DATA_WIDTH  head character
- frameErrorOut, parityErrorOut, breakOut  output  1 each  head flags
- fifoEmpty, fifoFull  output  1 each  status
- nrOfEntries  output  DEPTH_LOG2+1  occupancy, 0..2**DEPTH_LOG2
- fifoError  output  1  high while any stored entry carries any error flag
- overrun  output  1  one-cycle pulse when a push is dropped
- dataAvailIrq  output  1  occupancy >= triggerLevel (triggerLevel != 0)
- timeoutIrq  output  1  character-timeout interrupt

## Operation
- Storage: 2**DEPTH_LOG2 words of DATA_WIDTH+3 bits ({break, parity, frame, data}). Read/write pointers are DEPTH_LOG2 bits and wrap modulo depth. Occupancy counter is DEPTH_LOG2+1 bits.
- Push: accepted if not full, or if full and fifoRe is in the same cycle. If full without a pop, the character is dropped and overrun pulses.
- Pop: ignored when empty. Push+pop on empty performs the push only; there is no bypass.
- Push+pop when non-empty: both happen, occupancy unchanged.
- Head output: dataOut and head flags read the head word combinationally from registered storage. The value is undefined (implementation keeps last) when empty.
- fifoError: an error-entry counter increments on push of a flagged entry and decrements on pop of a flagged entry (both in the same cycle: net). fifoError = counter != 0.
- dataAvailIrq: combinational from registered nrOfEntries and triggerLevel.
- Timeout counter (16 bit):
  - Cleared on push, pop, flush, or when empty.
  - Otherwise increments on baudTick, saturating at 0xFFFF.
  - timeoutIrq sets when counter == timeoutTicks and timeoutTicks != 0.
  - timeoutIrq clears on pop, push, flush, or when timeoutTicks is written to 0.
- flush: pointers, occupancy, error counter, timeout counter and timeoutIrq return to reset values. A push in the same cycle as flush is discarded. flush wins over all other requests.

## Timing
- Reset (reset low, asynchronous):
  - fifoEmpty=1, fifoFull=0, nrOfEntries=0, fifoError=0
  - overrun=0, dataAvailIrq=0, timeoutIrq=0, dataOut=0, head flags=0
- fifoEmpty, fifoFull, nrOfEntries and fifoError are registered and reflect a push/pop in the cycle after the request edge.
- A pushed character is visible on dataOut 1 cycle after the push into an empty FIFO.
- overrun is registered, high for exactly 1 cycle, in the cycle after the dropped push.
- timeoutIrq asserts the cycle after the baudTick that makes the counter equal timeoutTicks.
- Reset released mid-operation: state is as after reset; no spurious overrun or interrupt.

## Configuration
- UART_RX_FIFO_TIMEOUT_EN defined: timeout counter and timeoutIrq logic are present as specified.
- Not defined: counter is removed, timeoutIrq is tied to 0, and baudTick and timeoutTicks are unused.

## Test plan
- DEPTH_LOG2=4: push 0x41..0x50 (16 chars) -> fifoFull=1, nrOfEntries=16. 17th push 0x51 -> overrun pulse 1 cycle, nrOfEntries stays 16. 16 pops return 0x41..0x50 in order, then fifoEmpty=1.
- Full FIFO, simultaneous push 0x7A and pop -> dataOut advances, nrOfEntries=16, no overrun; 0x7A is read last.
- triggerLevel=4: push 3 chars -> dataAvailIrq=0; 4th push -> dataAvailIrq=1 the next cycle; one pop -> 0.
- Push one char with parityErrorIn=1 among clean chars -> fifoError=1 until that entry is popped, then 0. parityErrorOut=1 only while it is head.
- timeoutTicks=64, one char stored, 64 baudTicks with no push/pop -> timeoutIrq=1. A pop clears it. With the macro undefined -> timeoutIrq stays 0.
- Drop reset low with 5 entries and timeoutIrq=1 -> all outputs at reset values immediately. After release, push 0x33 -> dataOut=0x33, nrOfEntries=1.
